pipe_add_n: RTL and testbench

PIPE_ADD_N -- requirements
Module: pipe_add_n

---
 rtl/pipe_add_pkg.sv | 12 +
 rtl/add_seg.sv | 15 +
 rtl/pipe_add_n.sv | 131 +++++++++++++
 tb/tb_pipe_add_n.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_add_pkg.sv
// rtl/pipe_add_pkg.sv - shared constants for the pipelined N-bit adder
package pipe_add_pkg;

  localparam int PIPE_ADD_DEFAULT_N      = 32;
  localparam int PIPE_ADD_DEFAULT_STAGES = 4;

  // Width of one carry-chain slice.
  function automatic int seg_width(input int n, input int stages);
    return n / stages;
  endfunction

endpackage

// File: rtl/add_seg.sv
// rtl/add_seg.sv - W-bit combinational adder slice
// Ports: a, b (W-bit operands), ci (carry in) -> s (W-bit sum), co (carry out).
module add_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipe_add_n.sv
// rtl/pipe_add_n.sv - N-bit adder/subtractor with the carry chain split over STAGES pipeline stages
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, ci, sub (operand side);
//        out_valid/out_ready, s, co (result side); ovf only when PIPE_ADD_OVF_EN is defined.
// Optional feature macro: PIPE_ADD_OVF_EN adds the pipelined signed-overflow output ovf.
module pipe_add_n
  import pipe_add_pkg::*;
#(
  parameter int N      = PIPE_ADD_DEFAULT_N,
  parameter int STAGES = PIPE_ADD_DEFAULT_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         co
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int W = seg_width(N, STAGES);

  // One global enable: the whole pipe moves together or holds together,
  // so in_ready never depends on in_valid.
  logic         adv;
  logic [N-1:0] b_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // RW: operand bits still unprocessed entering stage k; HI: those left after it.
    localparam int RW = N - k * W;
    localparam int HI = RW - W;

    logic [RW-1:0]        src_a;
    logic [RW-1:0]        src_b;
    logic                 src_c;
    logic                 src_v;
    logic [W-1:0]         seg_s;
    logic                 seg_co;
    logic [(k+1)*W-1:0]   s_d;
    logic [(k+1)*W-1:0]   s_q;
    logic                 c_q;
    logic                 v_q;

    if (k == 0) begin : g_head
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = ci;
      assign src_v = in_valid;
      assign s_d   = seg_s;
    end else begin : g_body
      assign src_a = g_stg[k-1].g_fwd.a_q;
      assign src_b = g_stg[k-1].g_fwd.b_q;
      assign src_c = g_stg[k-1].c_q;
      assign src_v = g_stg[k-1].v_q;
      // Completed lower slices ride along so the final word is coherent.
      assign s_d   = {seg_s, g_stg[k-1].s_q};
    end

    add_seg #(.W(W)) u_seg (
      .a  (src_a[W-1:0]),
      .b  (src_b[W-1:0]),
      .ci (src_c),
      .s  (seg_s),
      .co (seg_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= src_v;
        c_q <= seg_co;
        s_q <= s_d;
      end
    end

    // Upper operand slices not yet added are delayed to meet their carry.
    if (HI > 0) begin : g_fwd
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= src_a[RW-1:W];
          b_q <= src_b[RW-1:W];
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign s         = g_stg[STAGES-1].s_q;
  assign co        = g_stg[STAGES-1].c_q;

`ifdef PIPE_ADD_OVF_EN
  // Carry into the MSB is recovered from the top slice's sum bit.
  logic msb_cin;
  logic ovf_q;

  assign msb_cin = g_stg[STAGES-1].src_a[W-1] ^ g_stg[STAGES-1].src_b[W-1]
                 ^ g_stg[STAGES-1].seg_s[W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= msb_cin ^ g_stg[STAGES-1].seg_co;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_add_n.sv
// tb/tb_pipe_add_n.sv - self-checking bench for pipe_add_n (N=8, STAGES=2)
module tb_pipe_add_n;

  localparam int N  = 8;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         co;
`ifdef PIPE_ADD_OVF_EN
  logic         ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Expected results in issue order: {ovf, co, s}.
  logic [N+1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_add_n #(.N(N), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
`ifdef PIPE_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Integer-arithmetic reference: unsigned sum for s/co, signed range test for ovf.
  function automatic logic [N+1:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic c, input logic sb);
    int ux, uy, ur, sx, sy, sr;
    logic [N+1:0] res;
    ux = int'(x);
    uy = sb ? ((1 << N) - 1 - int'(y)) : int'(y);
    ur = ux + uy + int'(c);
    sx = (ux >= (1 << (N-1))) ? ux - (1 << N) : ux;
    sy = (uy >= (1 << (N-1))) ? uy - (1 << N) : uy;
    sr = sx + sy + int'(c);
    res[N-1:0] = ur[N-1:0];
    res[N]     = (ur >= (1 << N));
    res[N+1]   = (sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1)));
    return res;
  endfunction

  task automatic drive(input logic iv, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic c, input logic sb, input logic ordy);
    @(negedge clk);
    in_valid = iv; a = x; b = y; ci = c; sub = sb; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || s !== 8'h00 || co !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: out_valid=%b s=%h co=%b required 0/00/0", out_valid, s, co);
    end
`ifdef PIPE_ADD_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: ovf=%b required 0", ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [7] = '{8'hFF, 8'h05, 8'h07, 8'h7F, 8'h80, 8'h00, 8'hFF};
    logic [N-1:0] tb_ [7] = '{8'h01, 8'h07, 8'h05, 8'h01, 8'h01, 8'h00, 8'hFF};
    logic         tc [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [N+1:0] e;
    int lat;
    for (int i = 0; i < 7; i++) begin
      e = ref_add(ta[i], tb_[i], tc[i], ts[i]);
      drive(1'b1, ta[i], tb_[i], tc[i], ts[i], 1'b1);
      lat = 0;
      for (int t = 1; t <= 8; t++) begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        if (out_valid) begin
          lat = t;
          break;
        end
      end
      vectors++;
      if (lat != ST) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: latency=%0d required %0d", i, lat, ST);
      end
      vectors++;
      if (s !== e[N-1:0] || co !== e[N]) begin
        miscompares++;
        $display("FAIL directed_sum[%0d]: s=%h co=%b required s=%h co=%b", i, s, co, e[N-1:0], e[N]);
      end
`ifdef PIPE_ADD_OVF_EN
      vectors++;
      if (ovf !== e[N+1]) begin
        miscompares++;
        $display("FAIL directed_ovf[%0d]: ovf=%b required %b", i, ovf, e[N+1]);
      end
`endif
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] oa [3];
    logic [N-1:0] ob [3];
    logic [N-1:0] held_s;
    logic         held_co;
    logic [N+1:0] e;
    int sent = 0;
    int got  = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      oa[i] = N'($urandom);
      ob[i] = N'($urandom);
    end
    held_s = '0; held_co = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sent < 3) drive(1'b1, oa[sent], ob[sent], 1'b0, 1'b0, cyc >= 6);
      else          drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, cyc >= 6);
      if (cyc == 2) begin
        held_s = s; held_co = co;
      end
      if (cyc >= 2 && cyc <= 5) begin
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || s !== held_s || co !== held_co) begin
          miscompares++;
          $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b s=%h co=%b required 0/1/%h/%b",
                   cyc, in_ready, out_valid, s, co, held_s, held_co);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra: unexpected result s=%h required none", s);
        end else begin
          e = exp_q.pop_front();
          if (s !== e[N-1:0] || co !== e[N]) begin
            miscompares++;
            $display("FAIL bp_order[%0d]: s=%h co=%b required s=%h co=%b", got, s, co, e[N-1:0], e[N]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a, b, ci, sub));
        sent++;
      end
    end
    vectors++;
    if (got != 3) begin
      miscompares++;
      $display("FAIL bp_count: delivered=%0d required 3", got);
    end
  endtask

  task automatic test_random();
    logic [N+1:0] e;
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_s = '0;
    logic         prev_co = 1'b0;
    logic         iv, ordy;
    exp_q.delete();
    for (int cyc = 0; cyc < 320; cyc++) begin
      iv   = (cyc < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ordy = (cyc < 300) ? ($urandom_range(0, 9) < 7) : 1'b1;
      drive(iv, N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), ordy);
      vectors++;
      if (in_ready !== (!out_valid || out_ready)) begin
        miscompares++;
        $display("FAIL rnd_ready[%0d]: in_ready=%b required %b", cyc, in_ready, !out_valid || out_ready);
      end
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || s !== prev_s || co !== prev_co) begin
          miscompares++;
          $display("FAIL rnd_hold[%0d]: out_valid=%b s=%h co=%b required 1/%h/%b",
                   cyc, out_valid, s, co, prev_s, prev_co);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s = s; prev_co = co;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_extra[%0d]: unexpected result s=%h required none", cyc, s);
        end else begin
          e = exp_q.pop_front();
          if (s !== e[N-1:0] || co !== e[N]) begin
            miscompares++;
            $display("FAIL rnd_result[%0d]: s=%h co=%b required s=%h co=%b", cyc, s, co, e[N-1:0], e[N]);
          end
`ifdef PIPE_ADD_OVF_EN
          else if (ovf !== e[N+1]) begin
            miscompares++;
            $display("FAIL rnd_ovf[%0d]: ovf=%b required %b", cyc, ovf, e[N+1]);
          end
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, ci, sub));
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_drain: outstanding=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    logic seen = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_setup: out_valid=%b required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || s !== 8'h00 || co !== 1'b0) begin
      miscompares++;
      $display("FAIL inflight_reset: out_valid=%b s=%h co=%b required 0/00/0", out_valid, s, co);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL inflight_ghost: stale result seen=%b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
